// File: rtl/align_addsub_serial_if.sv
// rtl/align_addsub_serial_if.sv - operand/result handshake bundle for align_addsub_serial
// ALIGN_STICKY_EN adds the sticky result bit.
interface align_addsub_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        op_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pre_E;
  logic [23:0] MA;
  logic [23:0] MB;
  logic        op;
  logic        sign;
  logic        swap;
  logic        special;
`ifdef ALIGN_STICKY_EN
  logic        sticky;

  modport slave (
    input  in_valid, A, B, op_in, out_ready,
    output in_ready, out_valid, pre_E, MA, MB, op, sign, swap, special, sticky
  );
  modport master (
    output in_valid, A, B, op_in, out_ready,
    input  in_ready, out_valid, pre_E, MA, MB, op, sign, swap, special, sticky
  );
`else
  modport slave (
    input  in_valid, A, B, op_in, out_ready,
    output in_ready, out_valid, pre_E, MA, MB, op, sign, swap, special
  );
  modport master (
    output in_valid, A, B, op_in, out_ready,
    input  in_ready, out_valid, pre_E, MA, MB, op, sign, swap, special
  );
`endif
endinterface

// File: rtl/align_addsub_serial.sv
// rtl/align_addsub_serial.sv - FP add/sub operand ordering and one-bit-per-cycle mantissa alignment
// ALIGN_STICKY_EN adds the sticky output (OR of shifted-out MB bits).
module align_addsub_serial #(
  parameter int MAX_SHIFT = 24
) (
  input logic                  clk,
  input logic                  rst,
  align_addsub_serial_if.slave io
);
  localparam int              CW          = $clog2(MAX_SHIFT + 1);
  localparam logic [7:0]      MAX_SHIFT_E = 8'(MAX_SHIFT);
  localparam logic [CW-1:0]   MAX_SHIFT_N = CW'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;
  state_t state, state_n;

  logic [31:0]   ra, rb;
  logic          rop;

  logic [7:0]    w_e, wn_e;
  logic [23:0]   w_ma, wn_ma, w_mb, wn_mb;
  logic          w_op, wn_op, w_sign, wn_sign, w_swap, wn_swap;
  logic          w_special, wn_special, w_clamp, wn_clamp;
  logic [CW-1:0] cnt, cnt_n;
`ifdef ALIGN_STICKY_EN
  logic          w_sticky, wn_sticky;
`endif

  logic          b_gt;
  logic [31:0]   big, sml;
  logic [7:0]    e_big_eff, e_sml_eff, diff;
  logic          special_c, clamp_c;
  logic [CW-1:0] n_c;
  logic          entering_done;

  // Ordering uses raw {E,M}; alignment uses effective exponents (denormals count as E=1).
  always_comb begin
    b_gt      = rb[30:0] > ra[30:0];
    big       = b_gt ? rb : ra;
    sml       = b_gt ? ra : rb;
    e_big_eff = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml_eff = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    diff      = e_big_eff - e_sml_eff;
    special_c = (&ra[30:23]) | (&rb[30:23]);
    clamp_c   = !special_c && (diff > MAX_SHIFT_E);
    if (special_c)    n_c = '0;
    else if (clamp_c) n_c = MAX_SHIFT_N;
    else              n_c = diff[CW-1:0];
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wn_e       = w_e;
    wn_ma      = w_ma;
    wn_mb      = w_mb;
    wn_op      = w_op;
    wn_sign    = w_sign;
    wn_swap    = w_swap;
    wn_special = w_special;
    wn_clamp   = w_clamp;
`ifdef ALIGN_STICKY_EN
    wn_sticky  = w_sticky;
`endif
    case (state)
      IDLE: begin
        if (io.in_valid) begin
          state_n = CMP;
`ifdef ALIGN_STICKY_EN
          wn_sticky = 1'b0;
`endif
        end
      end
      CMP: begin
        wn_e       = special_c ? 8'hFF : big[30:23];
        wn_ma      = {(big[30:23] != 8'd0), big[22:0]};
        wn_mb      = {(sml[30:23] != 8'd0), sml[22:0]};
        wn_op      = rop ^ ra[31] ^ rb[31];
        wn_sign    = b_gt ? (rb[31] ^ rop) : ra[31];
        wn_swap    = b_gt;
        wn_special = special_c;
        wn_clamp   = clamp_c;
        cnt_n      = n_c;
        state_n    = (n_c == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        wn_mb = w_mb >> 1;
`ifdef ALIGN_STICKY_EN
        wn_sticky = w_sticky | w_mb[0];
`endif
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = DONE;
      end
      DONE: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign entering_done = (state != DONE) && (state_n == DONE);
  assign io.in_ready   = (state == IDLE);
  assign io.out_valid  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      rop       <= 1'b0;
      cnt       <= '0;
      w_e       <= '0;
      w_ma      <= '0;
      w_mb      <= '0;
      w_op      <= 1'b0;
      w_sign    <= 1'b0;
      w_swap    <= 1'b0;
      w_special <= 1'b0;
      w_clamp   <= 1'b0;
`ifdef ALIGN_STICKY_EN
      w_sticky  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      w_e       <= wn_e;
      w_ma      <= wn_ma;
      w_mb      <= wn_mb;
      w_op      <= wn_op;
      w_sign    <= wn_sign;
      w_swap    <= wn_swap;
      w_special <= wn_special;
      w_clamp   <= wn_clamp;
`ifdef ALIGN_STICKY_EN
      w_sticky  <= wn_sticky;
`endif
      if (state == IDLE && io.in_valid) begin
        ra  <= io.A;
        rb  <= io.B;
        rop <= io.op_in;
      end
    end
  end

  // Visible results move only on entry to DONE so the consumer sees one stable snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.pre_E   <= '0;
      io.MA      <= '0;
      io.MB      <= '0;
      io.op      <= 1'b0;
      io.sign    <= 1'b0;
      io.swap    <= 1'b0;
      io.special <= 1'b0;
`ifdef ALIGN_STICKY_EN
      io.sticky  <= 1'b0;
`endif
    end else if (entering_done) begin
      io.pre_E   <= wn_e;
      io.MA      <= wn_ma;
      io.MB      <= wn_clamp ? '0 : wn_mb;
      io.op      <= wn_op;
      io.sign    <= wn_sign;
      io.swap    <= wn_swap;
      io.special <= wn_special;
`ifdef ALIGN_STICKY_EN
      io.sticky  <= wn_sticky | (wn_clamp & (|wn_mb));
`endif
    end
  end
endmodule
